// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Instruction-fetch front end. Owns the program counter, issues single-beat
// AXI read-address requests for the 8-byte word containing the PC, keeps an
// ordered record of every request that is still waiting for its R beat, and
// hands the selected 32-bit instruction to decode over a valid/ready pair.
//
// A branch/jump redirect moves the PC at once. Fetches that are already in
// flight cannot be cancelled on the bus, so they are marked "drop" and their
// R beats are swallowed when they come back. An AR request that is waiting
// for ar_ready when the redirect arrives keeps its address (AXI does not
// allow it to change) and is tagged stale, so its entry is born dropped.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   fetch_en          allows new AR requests to be started
//   redirect_valid    redirect request (already prioritised upstream)
//   redirect_pc       redirect target; bits [1:0] are ignored
//   ar_*              AXI read-address channel (len 0, size 8 bytes)
//   r_*               AXI read-data channel; r_last is not needed for len 0
//   inst_valid/ready  handshake towards decode
//   inst, inst_pc     instruction word and the PC it was fetched from
//   inst_err          the R beat for this instruction had r_resp != 0
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int              ADDR_W      = 64,
    parameter int              DATA_W      = 64,
    parameter int              LEN_W       = 8,
    parameter int              OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [LEN_W-1:0]  ar_len,
    output logic [1:0]        ar_size,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

    // AR channel states: idle, presenting a live request, or presenting a
    // request that a redirect has already made useless.
    localparam logic [1:0] AR_IDLE  = 2'd0;
    localparam logic [1:0] AR_LIVE  = 2'd1;
    localparam logic [1:0] AR_STALE = 2'd2;

    logic [1:0]        ar_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] hold_pc;

    logic [ADDR_W-1:0] q_pc [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_drop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              ar_hs;
    logic              r_hs;
    logic              can_issue;
    logic              push_drop;
    logic              head_drop;
    logic [ADDR_W-1:0] head_pc;
    logic              load;
    logic [31:0]       inst_sel;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] pc_plus4;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic              unused_bits;

    assign ar_len  = '0;
    assign ar_size = 2'b11;
    assign ar_valid = (ar_state != AR_IDLE);

    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;

    // Responses are only taken when some request is outstanding and the
    // output register is free (or being emptied this very cycle).
    assign r_ready = (count != '0) && (!inst_valid || inst_ready);

    // A new request may start only from idle, with room in the in-flight
    // record, and never in a cycle that is itself redirecting the PC.
    assign can_issue = (ar_state == AR_IDLE) && fetch_en
                       && (count < MAX_CNT) && !redirect_valid;

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pc_plus4        = pc + ADDR_W'(4);

    // The entry being pushed is dead if its request was overtaken by an
    // earlier redirect or by one arriving in the handshake cycle.
    assign push_drop = (ar_state == AR_STALE) || redirect_valid;

    assign head_pc   = q_pc[rd_ptr];
    assign head_drop = q_drop[rd_ptr];

    // A beat reaches decode only if its entry is still wanted and no
    // redirect is killing everything in flight this cycle.
    assign load = r_hs && !head_drop && !redirect_valid;

    // pc[2] picks which half of the 8-byte beat holds the instruction.
    assign inst_sel = head_pc[2] ? r_data[63:32] : r_data[31:0];

    assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    assign unused_bits = ^{r_last, redirect_pc[1:0]};

    // AR channel. Address and hold PC are captured when a request starts and
    // are left untouched until the handshake, whatever else happens. A
    // redirect while waiting only downgrades the request to stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            ar_addr  <= '0;
            hold_pc  <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (can_issue) begin
                        ar_state <= AR_LIVE;
                        ar_addr  <= {pc[ADDR_W-1:3], 3'b000};
                        hold_pc  <= pc;
                    end
                end
                AR_LIVE: begin
                    if (ar_ready) begin
                        ar_state <= AR_IDLE;
                    end else if (redirect_valid) begin
                        ar_state <= AR_STALE;
                    end
                end
                AR_STALE: begin
                    if (ar_ready) begin
                        ar_state <= AR_IDLE;
                    end
                end
                default: begin
                    ar_state <= AR_IDLE;
                end
            endcase
        end
    end

    // Program counter. A redirect always wins. Otherwise the PC advances by
    // one instruction when a live request is accepted; a stale request's
    // acceptance leaves the PC on the redirect target, which still has to
    // be fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= START_ADDR;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if ((ar_state == AR_LIVE) && ar_ready) begin
            pc <= pc_plus4;
        end
    end

    // In-flight record payload: the full PC of each accepted request, in
    // issue order. Entries are only read while valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            q_pc[wr_ptr] <= hold_pc;
        end
    end

    // Drop flags. A redirect condemns every entry currently held; the entry
    // pushed in the same cycle is written afterwards with its own flag,
    // which push_drop already forces high on a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_drop <= '0;
        end else begin
            if (redirect_valid) begin
                q_drop <= '1;
            end
            if (ar_hs) begin
                q_drop[wr_ptr] <= push_drop;
            end
        end
    end

    // Queue pointers and occupancy. A push and a pop in the same cycle
    // leave the count unchanged. Overflow is impossible because a request
    // only starts while count is below the limit, and count cannot grow
    // again until that request itself is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ar_hs) begin
                wr_ptr <= wr_ptr_next;
            end
            if (r_hs) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({ar_hs, r_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register towards decode. A redirect empties it. A fresh beat
    // loads it, including in the cycle decode takes the previous one, which
    // gives back-to-back delivery. Otherwise an accepted word just leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_err   <= 1'b0;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
        end else if (load) begin
            inst_valid <= 1'b1;
            inst       <= inst_sel;
            inst_pc    <= head_pc;
            inst_err   <= (r_resp != 2'b00);
        end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

endmodule
